// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: instruction field
// positions, opcode-class decoding and the in-flight producer record.
package hazard_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RA_HI  = 20;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam int FIELD_W = 5;

    localparam logic [1:0] MEM_PREFIX  = 2'b01;
    localparam logic [1:0] ALUI_PREFIX = 2'b00;
    localparam int         ALUI_BIT    = 3;

    typedef enum logic [1:0] {
        CLS_ALUR,
        CLS_ALUI,
        CLS_LOAD,
        CLS_STORE
    } op_class_e;

    typedef struct packed {
        logic               valid;
        logic               wr;
        logic               is_load;
        logic [FIELD_W-1:0] rd;
    } trk_entry_t;

    // Memory-side control travelling down the EX and DM stages.
    typedef struct packed {
        logic               mem_en;
        logic               mem_rw;
        logic               is_load;
        logic [FIELD_W-1:0] rw;
    } strobe_t;

    function automatic op_class_e classify(input logic [5:0] op);
        if (op[5:4] == MEM_PREFIX) begin
            return op[0] ? CLS_STORE : CLS_LOAD;
        end
        if (op[5:4] == ALUI_PREFIX && op[ALUI_BIT]) begin
            return CLS_ALUI;
        end
        return CLS_ALUR;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Finds the youngest tracked producer of one source register and flags a
// load sitting in the youngest slot that the source depends on.
module fwd_match
    import hazard_pkg::*;
#(
    parameter  int NUM_FWD = 3,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  trk_entry_t         trk [NUM_FWD],
    input  logic [FIELD_W-1:0] src,
    input  logic               src_used,
    output logic [SEL_W-1:0]   sel,
    output logic               load_hit
);

    // Scan oldest to youngest so the youngest match is the one left in sel.
    always_comb begin
        sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (src_used && (src != '0) && trk[k].valid && trk[k].wr &&
                (trk[k].rd == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
        load_hit = src_used && (src != '0) && trk[0].valid &&
                   trk[0].is_load && (trk[0].rd == src);
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode, forwarding-select and load-use stall unit between IF/ID and EX/DM;
// tracks the last NUM_FWD accepted instructions as potential producers.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter  int INS_W   = 32,
    parameter  int REG_W   = 5,
    parameter  int NUM_FWD = 3,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic             dec_valid,
    output logic [5:0]       op_dec,
    output logic [15:0]      imm,
    output logic             imm_sel,
    output logic [SEL_W-1:0] mux_sel_A,
    output logic [SEL_W-1:0] mux_sel_B,
    output logic             mem_en_ex,
    output logic             mem_rw_ex,
    output logic             mem_mux_sel_dm,
    output logic [REG_W-1:0] RW_dm
);

    trk_entry_t trk_q [NUM_FWD];
    trk_entry_t trk_d [NUM_FWD];

    logic             dec_valid_q, dec_valid_d;
    logic [5:0]       op_q, op_d;
    logic [15:0]      imm_q, imm_d;
    logic             imm_sel_q, imm_sel_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    strobe_t          dec_stb_q, dec_stb_d;
    strobe_t          ex_stb_q, ex_stb_d;
    strobe_t          dm_stb_q, dm_stb_d;

    logic [5:0]         f_op;
    logic [FIELD_W-1:0] f_rd, f_ra, f_rb;
    logic [15:0]        f_imm;
    op_class_e          cls;
    logic               reads_b, writes, use_imm;
    logic [SEL_W-1:0]   hit_sel_a, hit_sel_b;
    logic               load_hit_a, load_hit_b;
    logic               stall, accept;

    assign f_op    = ins[OP_HI:OP_LO];
    assign f_rd    = ins[RD_HI:RD_LO];
    assign f_ra    = ins[RA_HI:RA_LO];
    assign f_rb    = ins[RB_HI:RB_LO];
    assign f_imm   = ins[IMM_HI:IMM_LO];
    assign cls     = classify(f_op);
    assign reads_b = (cls == CLS_ALUR) || (cls == CLS_STORE);
    assign writes  = (cls != CLS_STORE);
    assign use_imm = (cls == CLS_ALUI) || (cls == CLS_LOAD);

    fwd_match #(.NUM_FWD(NUM_FWD)) u_match_a (
        .trk      (trk_q),
        .src      (f_ra),
        .src_used (1'b1),
        .sel      (hit_sel_a),
        .load_hit (load_hit_a)
    );

    fwd_match #(.NUM_FWD(NUM_FWD)) u_match_b (
        .trk      (trk_q),
        .src      (f_rb),
        .src_used (reads_b),
        .sel      (hit_sel_b),
        .load_hit (load_hit_b)
    );

    // A stalled cycle holds ins at fetch and pushes a bubble everywhere else.
    assign stall     = ins_valid && (load_hit_a || load_hit_b);
    assign accept    = ins_valid && !stall;
    assign ins_ready = !stall;

    always_comb begin
        trk_d       = trk_q;
        dec_valid_d = 1'b0;
        op_d        = '0;
        imm_d       = '0;
        imm_sel_d   = 1'b0;
        sel_a_d     = '0;
        sel_b_d     = '0;
        dec_stb_d   = '0;

        trk_d[0] = '0;
        for (int i = 1; i < NUM_FWD; i++) begin
            trk_d[i] = trk_q[i-1];
        end

        if (accept) begin
            trk_d[0].valid   = 1'b1;
            trk_d[0].wr      = writes;
            trk_d[0].is_load = (cls == CLS_LOAD);
            trk_d[0].rd      = f_rd;

            dec_valid_d = 1'b1;
            op_d        = f_op;
            imm_d       = f_imm;
            imm_sel_d   = use_imm;
            sel_a_d     = hit_sel_a;
            sel_b_d     = use_imm ? '0 : hit_sel_b;

            dec_stb_d.mem_en  = (cls == CLS_LOAD) || (cls == CLS_STORE);
            dec_stb_d.mem_rw  = (cls == CLS_STORE);
            dec_stb_d.is_load = (cls == CLS_LOAD);
            dec_stb_d.rw      = writes ? f_rd : '0;
        end

        ex_stb_d = dec_stb_q;
        dm_stb_d = ex_stb_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q       <= '{default: '0};
            dec_valid_q <= 1'b0;
            op_q        <= '0;
            imm_q       <= '0;
            imm_sel_q   <= 1'b0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            dec_stb_q   <= '0;
            ex_stb_q    <= '0;
            dm_stb_q    <= '0;
        end else begin
            trk_q       <= trk_d;
            dec_valid_q <= dec_valid_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            imm_sel_q   <= imm_sel_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            dec_stb_q   <= dec_stb_d;
            ex_stb_q    <= ex_stb_d;
            dm_stb_q    <= dm_stb_d;
        end
    end

    assign dec_valid      = dec_valid_q;
    assign op_dec         = op_q;
    assign imm            = imm_q;
    assign imm_sel        = imm_sel_q;
    assign mux_sel_A      = sel_a_q;
    assign mux_sel_B      = sel_b_q;
    assign mem_en_ex      = ex_stb_q.mem_en;
    assign mem_rw_ex      = ex_stb_q.mem_rw;
    assign mem_mux_sel_dm = dm_stb_q.is_load;
    assign RW_dm          = REG_W'(dm_stb_q.rw);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: hand-derived vector table, reset-mid-stall
// sequence and random traffic against a history-list reference model.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic        ins_valid;

    logic        ins_ready, dec_valid, imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm;
    logic [5:0]  op_dec;
    logic [15:0] imm;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic [4:0]  RW_dm;

    logic        ins_ready2, dec_valid2, imm_sel2, mem_en_ex2, mem_rw_ex2, mem_mux_sel_dm2;
    logic [5:0]  op_dec2;
    logic [15:0] imm2;
    logic [1:0]  mux_sel_A2, mux_sel_B2;
    logic [4:0]  RW_dm2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.INS_W(32), .REG_W(5), .NUM_FWD(3)) u_dut (
        .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .dec_valid(dec_valid), .op_dec(op_dec), .imm(imm),
        .imm_sel(imm_sel), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_mux_sel_dm(mem_mux_sel_dm), .RW_dm(RW_dm)
    );

    hazard_fwd_unit #(.INS_W(32), .REG_W(5), .NUM_FWD(2)) u_dut2 (
        .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ins_ready2), .dec_valid(dec_valid2), .op_dec(op_dec2), .imm(imm2),
        .imm_sel(imm_sel2), .mux_sel_A(mux_sel_A2), .mux_sel_B(mux_sel_B2),
        .mem_en_ex(mem_en_ex2), .mem_rw_ex(mem_rw_ex2),
        .mem_mux_sel_dm(mem_mux_sel_dm2), .RW_dm(RW_dm2)
    );

    typedef struct {
        bit valid;
        int op;
        int imm;
        bit imm_sel;
        int sa, sb, sa2, sb2;
        bit is_mem, is_store, is_load, writes;
        int rd;
    } dec_t;

    // hist[0] is what entered decode at the latest edge, hist[1] one older...
    dec_t hist [8];

    typedef struct {
        logic [31:0] w;
        bit v;
        bit rdy, dv;
        int sa, sb, sa2, sb2;
        bit isel, men, mrw, mdm;
        int rwdm;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] mk(input int unsigned op, input int unsigned rd,
                                       input int unsigned ra, input int unsigned low16);
        return 32'((op << 26) | (rd << 21) | (ra << 16) | low16);
    endfunction

    function automatic int fsel(input int s, input int nf);
        if (s == 0) return 0;
        for (int k = 1; k <= nf; k++) begin
            if (hist[k-1].valid && hist[k-1].writes && hist[k-1].rd == s) return k;
        end
        return 0;
    endfunction

    function automatic bit lu(input int s);
        return (s != 0) && hist[0].valid && hist[0].is_load && (hist[0].rd == s);
    endfunction

    function automatic dec_t model_decode(input logic [31:0] w, input bit v, output bit ready);
        dec_t r;
        int op, rd, ra, rb, grp;
        bit is_mem, is_store, is_load, is_alui, is_alur, reads_b;
        r = '{default: 0};
        op = int'(w[31:26]);
        rd = int'(w[25:21]);
        ra = int'(w[20:16]);
        rb = int'(w[15:11]);
        grp = op / 16;
        is_mem   = (grp == 1);
        is_store = is_mem && (op % 2 == 1);
        is_load  = is_mem && !is_store;
        is_alui  = (grp == 0) && ((op / 8) % 2 == 1);
        is_alur  = !is_mem && !is_alui;
        reads_b  = is_alur || is_store;
        ready = !(v && (lu(ra) || (reads_b && lu(rb))));
        if (!v || !ready) return r;
        r.valid    = 1;
        r.op       = op;
        r.imm      = int'(w[15:0]);
        r.imm_sel  = is_alui || is_load;
        r.sa       = fsel(ra, 3);
        r.sb       = reads_b ? fsel(rb, 3) : 0;
        r.sa2      = fsel(ra, 2);
        r.sb2      = reads_b ? fsel(rb, 2) : 0;
        r.is_mem   = is_mem;
        r.is_store = is_store;
        r.is_load  = is_load;
        r.writes   = !is_store;
        r.rd       = rd;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w, input bit v);
        ins       = w;
        ins_valid = v;
    endtask

    task automatic checkModelOutputs();
        int rw;
        rw = hist[2].writes ? hist[2].rd : 0;
        checkOutput("dec_valid", dec_valid, hist[0].valid);
        checkOutput("op_dec", op_dec, hist[0].op);
        checkOutput("imm", imm, hist[0].imm);
        checkOutput("imm_sel", imm_sel, hist[0].imm_sel);
        checkOutput("mux_sel_A", mux_sel_A, hist[0].sa);
        checkOutput("mux_sel_B", mux_sel_B, hist[0].sb);
        checkOutput("mem_en_ex", mem_en_ex, hist[1].is_mem);
        checkOutput("mem_rw_ex", mem_rw_ex, hist[1].is_store);
        checkOutput("mem_mux_sel_dm", mem_mux_sel_dm, hist[2].is_load);
        checkOutput("RW_dm", RW_dm, rw);
        checkOutput("nf2 dec_valid", dec_valid2, hist[0].valid);
        checkOutput("nf2 op_dec", op_dec2, hist[0].op);
        checkOutput("nf2 imm", imm2, hist[0].imm);
        checkOutput("nf2 imm_sel", imm_sel2, hist[0].imm_sel);
        checkOutput("nf2 mux_sel_A", mux_sel_A2, hist[0].sa2);
        checkOutput("nf2 mux_sel_B", mux_sel_B2, hist[0].sb2);
        checkOutput("nf2 mem_en_ex", mem_en_ex2, hist[1].is_mem);
        checkOutput("nf2 mem_rw_ex", mem_rw_ex2, hist[1].is_store);
        checkOutput("nf2 mem_mux_sel_dm", mem_mux_sel_dm2, hist[2].is_load);
        checkOutput("nf2 RW_dm", RW_dm2, rw);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 8; i++) hist[i] = '{default: 0};
    endtask

    // One clock: drive, check ins_ready before the edge, check registers after it.
    task automatic runCycle(input logic [31:0] w, input bit v, output bit ready, output logic seen);
        dec_t rec;
        applyStimulus(w, v);
        #1;
        rec  = model_decode(w, v, ready);
        seen = ins_ready;
        checkOutput("ins_ready", ins_ready, ready);
        checkOutput("nf2 ins_ready", ins_ready2, ready);
        @(posedge clk);
        #1;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = rec;
        checkModelOutputs();
    endtask

    function automatic logic [31:0] rand_ins();
        int unsigned ops [8] = '{32'h00, 32'h04, 32'h0D, 32'h08, 32'h14, 32'h15, 32'h3F, 32'h24};
        int unsigned rb;
        rb = $urandom_range(0, 3);
        return mk(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                  (rb << 11) | $urandom_range(0, 2047));
    endfunction

    initial begin
        bit          rdy;
        logic        seen;
        logic [31:0] w;
        bit          v;
        bit          pend;
        logic [31:0] stall_ins;

        //          ins                           v  rdy dv sa sb sa2 sb2 isel men mrw mdm rwdm
        tbl[0]  = '{mk(6'h00, 1, 2, 3 << 11),  1, 1,  1, 0, 0, 0,  0,  0,   0,  0,  0,  0};
        tbl[1]  = '{mk(6'h04, 5, 1, 4 << 11),  1, 1,  1, 1, 0, 1,  0,  0,   0,  0,  0,  0};
        tbl[2]  = '{mk(6'h14, 4, 1, 0),        1, 1,  1, 2, 0, 2,  0,  1,   0,  0,  0,  1};
        tbl[3]  = '{mk(6'h00, 6, 4, 2 << 11),  1, 0,  0, 0, 0, 0,  0,  0,   1,  0,  0,  5};
        tbl[4]  = '{mk(6'h00, 6, 4, 2 << 11),  1, 1,  1, 2, 0, 2,  0,  0,   0,  0,  1,  4};
        tbl[5]  = '{mk(6'h00, 1, 0, 0),        1, 1,  1, 0, 0, 0,  0,  0,   0,  0,  0,  0};
        tbl[6]  = '{mk(6'h00, 0, 0, 0),        0, 1,  0, 0, 0, 0,  0,  0,   0,  0,  0,  6};
        tbl[7]  = '{mk(6'h00, 0, 0, 0),        0, 1,  0, 0, 0, 0,  0,  0,   0,  0,  0,  1};
        tbl[8]  = '{mk(6'h0D, 6, 1, 5),        1, 1,  1, 3, 0, 0,  0,  1,   0,  0,  0,  0};
        tbl[9]  = '{mk(6'h15, 7, 6, 1 << 11),  1, 1,  1, 1, 0, 1,  0,  0,   0,  0,  0,  0};
        tbl[10] = '{mk(6'h00, 8, 7, 7 << 11),  1, 1,  1, 0, 0, 0,  0,  0,   1,  1,  0,  6};
        tbl[11] = '{mk(6'h00, 0, 3, 3 << 11),  1, 1,  1, 0, 0, 0,  0,  0,   0,  0,  0,  0};
        tbl[12] = '{mk(6'h00, 9, 0, 0),        1, 1,  1, 0, 0, 0,  0,  0,   0,  0,  0,  8};
        tbl[13] = '{mk(6'h14, 2, 0, 0),        1, 1,  1, 0, 0, 0,  0,  1,   0,  0,  0,  0};
        tbl[14] = '{mk(6'h14, 3, 9, 0),        1, 1,  1, 2, 0, 2,  0,  1,   1,  0,  0,  9};
        tbl[15] = '{mk(6'h00, 10, 3, 2 << 11), 1, 0,  0, 0, 0, 0,  0,  0,   1,  0,  1,  2};
        tbl[16] = '{mk(6'h00, 10, 3, 2 << 11), 1, 1,  1, 2, 3, 2,  0,  0,   0,  0,  1,  3};

        clearModel();
        reset = 1'b1;
        applyStimulus(32'h0, 1'b0);
        #7;
        reset = 1'b0;
        checkOutput("reset ins_ready", ins_ready, 1);
        checkModelOutputs();

        $display("[TB] directed vector table");
        for (int i = 0; i < 17; i++) begin
            logic [31:0] wv;
            wv = tbl[i].w;
            runCycle(wv, tbl[i].v, rdy, seen);
            checkOutput($sformatf("tbl%0d ins_ready", i), seen, tbl[i].rdy);
            checkOutput($sformatf("tbl%0d dec_valid", i), dec_valid, tbl[i].dv);
            checkOutput($sformatf("tbl%0d op_dec", i), op_dec, tbl[i].dv ? wv[31:26] : 6'd0);
            checkOutput($sformatf("tbl%0d imm", i), imm, tbl[i].dv ? wv[15:0] : 16'd0);
            checkOutput($sformatf("tbl%0d mux_sel_A", i), mux_sel_A, tbl[i].sa);
            checkOutput($sformatf("tbl%0d mux_sel_B", i), mux_sel_B, tbl[i].sb);
            checkOutput($sformatf("tbl%0d nf2 mux_sel_A", i), mux_sel_A2, tbl[i].sa2);
            checkOutput($sformatf("tbl%0d nf2 mux_sel_B", i), mux_sel_B2, tbl[i].sb2);
            checkOutput($sformatf("tbl%0d imm_sel", i), imm_sel, tbl[i].isel);
            checkOutput($sformatf("tbl%0d mem_en_ex", i), mem_en_ex, tbl[i].men);
            checkOutput($sformatf("tbl%0d mem_rw_ex", i), mem_rw_ex, tbl[i].mrw);
            checkOutput($sformatf("tbl%0d mem_mux_sel_dm", i), mem_mux_sel_dm, tbl[i].mdm);
            checkOutput($sformatf("tbl%0d RW_dm", i), RW_dm, tbl[i].rwdm);
        end

        $display("[TB] reset asserted during a load-use stall");
        runCycle(mk(6'h14, 5, 0, 0), 1'b1, rdy, seen);
        stall_ins = mk(6'h00, 6, 5, 0);
        applyStimulus(stall_ins, 1'b1);
        #1;
        checkOutput("midstall ins_ready before reset", ins_ready, 0);
        reset = 1'b1;
        #1;
        clearModel();
        checkOutput("midstall ins_ready in reset", ins_ready, 1);
        checkOutput("midstall nf2 ins_ready in reset", ins_ready2, 1);
        checkModelOutputs();
        #3;
        reset = 1'b0;
        runCycle(stall_ins, 1'b1, rdy, seen);
        checkOutput("post-flush ins_ready", seen, 1);
        checkOutput("post-flush mux_sel_A", mux_sel_A, 0);
        checkOutput("post-flush dec_valid", dec_valid, 1);

        $display("[TB] random traffic");
        pend = 1'b0;
        w    = '0;
        v    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                w = rand_ins();
                v = ($urandom_range(0, 9) != 0);
            end
            runCycle(w, v, rdy, seen);
            pend = v && !rdy;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
